muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit, parametrised in data width, sitting beside the single-cycle ALU in the execute stage. Decodes opcode/funct3/funct7 for the M extension, accepts one operation through a valid/ready handshake, computes it over multiple cycles with a shift-add multiplier or restoring divider, and returns the result through a second valid/ready handshake. Special cases (divide-by-zero, signed overflow) complete on a fast path. The pipeline stalls on `busy` and can kill an in-flight operation with `flush`.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_dec.sv | 32 +++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants and state encoding for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32) ();
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic            is_muldiv;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output opcode, funct3, funct7, a, b, in_valid, flush, out_ready,
    input  in_ready, is_muldiv, out_valid, result, busy
  );

  modport slave (
    input  opcode, funct3, funct7, a, b, in_valid, flush, out_ready,
    output in_ready, is_muldiv, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_dec.sv
// funct3 decoder for the M extension: operand signedness and result selection.
module muldiv_dec
  import muldiv_pkg::*;
(
  input  logic [2:0] funct3,
  output logic       is_div,
  output logic       a_signed,
  output logic       b_signed,
  output logic       sel_high,
  output logic       sel_rem
);

  always_comb begin
    is_div   = 1'b0;
    a_signed = 1'b0;
    b_signed = 1'b0;
    sel_high = 1'b0;
    sel_rem  = 1'b0;
    case (funct3)
      F3_MUL:    begin a_signed = 1'b1; b_signed = 1'b1; end
      F3_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; sel_high = 1'b1; end
      F3_MULHSU: begin a_signed = 1'b1; sel_high = 1'b1; end
      F3_MULHU:  begin sel_high = 1'b1; end
      F3_DIV:    begin is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
      F3_DIVU:   begin is_div = 1'b1; end
      F3_REM:    begin is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; sel_rem = 1'b1; end
      F3_REMU:   begin is_div = 1'b1; sel_rem = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// on magnitudes, sign fix in FIX, fast path for divide-by-zero and signed overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input logic clk,
  input logic rst_n,
  muldiv_if.slave bus
);

  state_e state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   res_q;
  logic              neg_q, neg_r;
  logic              is_div_q, sel_high_q, sel_rem_q;

  logic d_is_div, d_a_signed, d_b_signed, d_sel_high, d_sel_rem;

  muldiv_dec u_dec (
    .funct3   (bus.funct3),
    .is_div   (d_is_div),
    .a_signed (d_a_signed),
    .b_signed (d_b_signed),
    .sel_high (d_sel_high),
    .sel_rem  (d_sel_rem)
  );

  logic            accept, a_neg, b_neg, div_zero, div_ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign bus.is_muldiv = (bus.opcode == OP) && (bus.funct7 == MULDIV);
  assign accept = bus.in_valid && bus.in_ready && bus.is_muldiv && !bus.flush;

  assign a_neg    = d_a_signed & bus.a[XLEN-1];
  assign b_neg    = d_b_signed & bus.b[XLEN-1];
  assign a_mag    = a_neg ? ('0 - bus.a) : bus.a;
  assign b_mag    = b_neg ? ('0 - bus.b) : bus.b;
  assign div_zero = d_is_div && (bus.b == '0);
  assign div_ovf  = d_is_div && d_a_signed && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
  assign fast     = div_zero || div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = d_sel_rem ? bus.a : '1;
    else          fast_res = d_sel_rem ? '0 : bus.a;
  end

  // Multiply: acc = {partial, multiplier}; add the multiplicand into the high half
  // when the multiplier LSB is set, then shift the whole register right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor.
  logic [XLEN:0]     div_part;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_nxt;
  assign div_part = acc[2*XLEN-1:XLEN-1];
  assign div_ge   = div_part >= {1'b0, opnd};
  assign div_diff = div_part[XLEN-1:0] - opnd;
  assign div_nxt  = {(div_ge ? div_diff : div_part[XLEN-1:0]), acc[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;
  always_comb begin
    prod = neg_q ? ('0 - acc) : acc;
    quot = neg_q ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = neg_r ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    if (is_div_q) fix_res = sel_rem_q ? rem : quot;
    else          fix_res = sel_high_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(XLEN - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      res_q      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      is_div_q   <= 1'b0;
      sel_high_q <= 1'b0;
      sel_rem_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt        <= '0;
          neg_q      <= a_neg ^ b_neg;
          neg_r      <= a_neg;
          is_div_q   <= d_is_div;
          sel_high_q <= d_sel_high;
          sel_rem_q  <= d_sel_rem;
          if (d_is_div) begin
            acc  <= {{XLEN{1'b0}}, a_mag};
            opnd <= b_mag;
          end else begin
            acc  <= {{XLEN{1'b0}}, b_mag};
            opnd <= a_mag;
          end
          if (fast) res_q <= fast_res;
        end
        CALC: begin
          acc <= is_div_q ? div_nxt : mul_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        FIX:     res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus handshake, abort and reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          n;    // edges after the accepting edge until out_valid is seen
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Present one M-extension request for a single edge; caller ensures in_ready.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.opcode   = OP;
    bus.funct7   = MULDIV;
    bus.funct3   = f3;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output logic busy_ok);
    n       = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && n < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int   n;
    logic busy_ok;
    logic seen;

    vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[5]  = '{F3_MUL,    32'h12345678, 32'd9,        32'hA3D70A38, 33};
    vecs[6]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[7]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[8]  = '{F3_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vecs[9]  = '{F3_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        33};
    vecs[10] = '{F3_REMU,   32'd100,      32'd7,        32'd2,        33};
    // Fast path: out_valid is already up in the cycle right after accept.
    vecs[11] = '{F3_DIVU,   32'd7,        32'd0,        32'hFFFFFFFF, 0};
    vecs[12] = '{F3_REM,    32'd7,        32'd0,        32'd7,        0};
    vecs[13] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[14] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
    vecs[15] = '{F3_DIV,    32'd0,        32'd5,        32'd0,        33};

    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("reset in_ready",  32'(bus.in_ready),  32'd1);
    check("reset busy",      32'(bus.busy),      32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result",    bus.result,         32'd0);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_valid(n, busy_ok);
      check($sformatf("v%0d result", i),  bus.result, vecs[i].exp);
      check($sformatf("v%0d latency", i), 32'(n),      32'(vecs[i].n));
      if (vecs[i].n > 0) check($sformatf("v%0d busy", i), 32'(busy_ok), 32'd1);
      consume();
      check($sformatf("v%0d in_ready after consume", i), 32'(bus.in_ready), 32'd1);
    end

    // Backpressure: result and out_valid hold while out_ready stays low.
    issue(F3_DIVU, 32'd100, 32'd7);
    wait_valid(n, busy_ok);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d result", c),    bus.result,          32'd14);
      check($sformatf("bp%0d out_valid", c), 32'(bus.out_valid),  32'd1);
      check($sformatf("bp%0d in_ready", c),  32'(bus.in_ready),   32'd0);
      @(posedge clk); #1;
    end
    consume();
    check("bp in_ready after consume",  32'(bus.in_ready),  32'd1);
    check("bp out_valid after consume", 32'(bus.out_valid), 32'd0);

    // Flush ten cycles into a multiply.
    issue(F3_MUL, 32'd7, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    check("flush busy before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    check("flush in_ready",  32'(bus.in_ready),  32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush no late out_valid", 32'(seen), 32'd0);

    // flush together with in_valid: nothing is accepted.
    bus.opcode   = OP;
    bus.funct7   = MULDIV;
    bus.funct3   = F3_MUL;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush+in_valid busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of a divide; result still holds 14 from before.
    issue(F3_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst in_ready",  32'(bus.in_ready),  32'd1);
    check("midrst busy",      32'(bus.busy),      32'd0);
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst result",    bus.result,         32'd0);
    rst_n = 1'b1;

    // Base-ISA R-type (funct7 0) is never accepted.
    bus.opcode   = OP;
    bus.funct7   = 7'b0000000;
    bus.funct3   = F3_MUL;
    bus.in_valid = 1'b1;
    #1;
    check("non-M is_muldiv", 32'(bus.is_muldiv), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.busy) seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("non-M busy", 32'(seen), 32'd0);
    bus.funct7 = MULDIV;
    #1;
    check("M is_muldiv", 32'(bus.is_muldiv), 32'd1);

    // Recovery after the abort sequences.
    issue(F3_MUL, 32'd5, 32'd6);
    wait_valid(n, busy_ok);
    check("recover result",  bus.result, 32'd30);
    check("recover latency", 32'(n),     32'd33);
    consume();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
